// File: rtl/arith_pkg.sv
// Shared types and helpers for the arithmetic library blocks.
package arith_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor_1b.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first: DIFF = A - B - BIN over WIDTH RUN cycles.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] DIFF,
  output logic             BOUT,
  output logic             ZERO
);

  localparam int CW = clog2(WIDTH);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_d;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout, r_zero, r_done;
  logic             w_d, w_bo;

  full_subtractor_1b u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) w_next = DONE;
      end
      DONE: begin
        busy   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_d    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
      r_done <= 1'b0;
    end else begin
      // done is registered so it rises in the same cycle as the new result
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: if (start) begin
          r_a   <= A;
          r_b   <= B;
          r_br  <= BIN;
          r_d   <= '0;
          r_cnt <= '0;
        end
        RUN: begin
          r_d   <= {w_d, r_d[WIDTH-1:1]};
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_br  <= w_bo;
          r_cnt <= r_cnt + 1'b1;
        end
        DONE: begin
          r_diff <= r_d;
          r_bout <= r_br;
          r_zero <= (r_d == '0);
        end
        default: ;
      endcase
    end
  end

  assign done = r_done;
  assign DIFF = r_diff;
  assign BOUT = r_bout;
  assign ZERO = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic       clk, rst_n;
  logic       s4_start, s4_bin, s8_start, s8_bin;
  logic [3:0] s4_a, s4_b, diff4;
  logic [7:0] s8_a, s8_b, diff8;
  logic       busy4, done4, bout4, zero4;
  logic       busy8, done8, bout8, zero8;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(s4_start), .A(s4_a), .B(s4_b), .BIN(s4_bin),
    .busy(busy4), .done(done4), .DIFF(diff4), .BOUT(bout4), .ZERO(zero4)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .A(s8_a), .B(s8_b), .BIN(s8_bin),
    .busy(busy8), .done(done8), .DIFF(diff8), .BOUT(bout8), .ZERO(zero8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_diff(input int w);
    return (w == 4) ? {28'd0, diff4} : {24'd0, diff8};
  endfunction
  function automatic logic cur_done(input int w);
    return (w == 4) ? done4 : done8;
  endfunction
  function automatic logic cur_busy(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction
  function automatic logic cur_bout(input int w);
    return (w == 4) ? bout4 : bout8;
  endfunction
  function automatic logic cur_zero(input int w);
    return (w == 4) ? zero4 : zero8;
  endfunction

  task automatic set_start(input int w, input logic v);
    if (w == 4) s4_start = v;
    else        s8_start = v;
  endtask

  // Called at a negedge; returns at a negedge. With hold=1 start stays high
  // so the next call's operands are taken on the following edge.
  task automatic run_op(input int w, input int a, input int b, input int bin, input bit hold);
    int          mask, exp_diff, k, nb;
    bit          exp_bout, held_ok, seen;
    logic [31:0] prev;
    mask     = (1 << w) - 1;
    a        = a & mask;
    b        = b & mask;
    exp_diff = (a - b - bin) & mask;
    exp_bout = (a < b + bin);
    if (w == 4) begin s4_a = 4'(a); s4_b = 4'(b); s4_bin = bin[0]; end
    else        begin s8_a = 8'(a); s8_b = 8'(b); s8_bin = bin[0]; end
    set_start(w, 1'b1);
    prev = cur_diff(w);
    @(posedge clk);
    @(negedge clk);
    if (!hold) set_start(w, 1'b0);
    k = 1; nb = 0; held_ok = 1; seen = 0;
    while (k <= w + 10) begin
      if (cur_done(w)) begin seen = 1; break; end
      if (cur_busy(w)) nb++;
      if (cur_diff(w) != prev) held_ok = 0;
      @(negedge clk);
      k++;
    end
    chk("done_seen", seen, 1'b1);
    chk("latency", k, w + 2);
    chk("busy_cycles", nb, w + 1);
    chk("diff_hold", held_ok, 1'b1);
    chk("diff", cur_diff(w), exp_diff);
    chk("bout", cur_bout(w), exp_bout);
    chk("zero", cur_zero(w), exp_diff == 0);
    if (!hold) begin
      @(negedge clk);
      chk("done_pulse", cur_done(w), 1'b0);
    end
  endtask

  initial begin
    int ndone;
    logic [31:0] got;
    rst_n = 1'b0;
    s4_start = 0; s4_a = 0; s4_b = 0; s4_bin = 0;
    s8_start = 0; s8_a = 0; s8_b = 0; s8_bin = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_diff", diff4, 0);
    chk("rst_bout", bout4, 0);
    chk("rst_zero", zero4, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(4, 9, 3, 0, 0);
    run_op(4, 3, 9, 0, 0);
    run_op(4, 5, 5, 0, 0);
    run_op(4, 0, 0, 1, 0);
    run_op(4, 15, 0, 0, 0);

    // start during RUN is ignored
    s4_a = 9; s4_b = 3; s4_bin = 0; s4_start = 1;
    @(posedge clk);
    @(negedge clk); s4_start = 0;
    @(negedge clk); s4_start = 1; s4_a = 1; s4_b = 1;
    @(negedge clk); s4_start = 0;
    ndone = 0; got = 0;
    repeat (12) begin
      if (done4) begin ndone++; got = {28'd0, diff4}; end
      @(negedge clk);
    end
    chk("busy_start_ndone", ndone, 1);
    chk("busy_start_diff", got, 6);

    // asynchronous reset in the second RUN cycle
    s4_a = 9; s4_b = 3; s4_start = 1;
    @(posedge clk);
    @(negedge clk); s4_start = 0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy4, 0);
    chk("midrst_done", done4, 0);
    chk("midrst_diff", diff4, 0);
    chk("midrst_bout", bout4, 0);
    chk("midrst_zero", zero4, 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      if (done4 || busy4) ndone++;
      @(negedge clk);
    end
    chk("midrst_quiet", ndone, 0);
    run_op(4, 12, 4, 0, 0);

    // exhaustive WIDTH=4 with start held high
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_op(4, a, b, c, 1);
    s4_start = 0;
    @(negedge clk);

    // random WIDTH=8 with start held high, boundaries first
    run_op(8, 0, 0, 1, 1);
    run_op(8, 255, 0, 0, 1);
    run_op(8, 0, 255, 1, 1);
    for (int i = 0; i < 2000; i++)
      run_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1)), 1);
    s8_start = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
